// File: rtl/mem_axi_lite_master.sv
// Mem-interface to AXI4-Lite master bridge with independent write and read FSMs.
// Optional macro AXI_RESP_CHECK_EN: a non-OKAY B/R response sets a sticky axi_err flag.
module mem_axi_lite_master #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [STRB_WIDTH-1:0] mem_wmask,
    output logic                  mem_wvalid,
    input  logic                  mem_ren,
    input  logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rvalid,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [STRB_WIDTH-1:0] m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic                  axi_err,
    output logic [1:0]            debug_wstate,
    output logic [1:0]            debug_rstate
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0] wstate;
    logic [1:0] rstate;

    assign m_awprot     = 3'b000;
    assign m_arprot     = 3'b000;
    assign mem_wvalid   = (wstate == ST_DONE);
    assign mem_rvalid   = (rstate == ST_DONE);
    assign debug_wstate = wstate;
    assign debug_rstate = rstate;

    // AW and W may complete in either order; leave ADDR once neither is still pending.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate    <= ST_IDLE;
            m_awaddr  <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
        end else begin
            case (wstate)
                ST_IDLE: begin
                    if (mem_wen) begin
                        m_awaddr  <= mem_waddr;
                        m_wdata   <= mem_wdata;
                        m_wstrb   <= mem_wmask;
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        wstate    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_awvalid && m_awready) m_awvalid <= 1'b0;
                    if (m_wvalid && m_wready) m_wvalid <= 1'b0;
                    if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
                        m_bready <= 1'b1;
                        wstate   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (m_bvalid) begin
                        m_bready <= 1'b0;
                        wstate   <= ST_DONE;
                    end
                end
                default: wstate <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate    <= ST_IDLE;
            m_araddr  <= '0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            mem_rdata <= '0;
        end else begin
            case (rstate)
                ST_IDLE: begin
                    if (mem_ren) begin
                        m_araddr  <= mem_raddr;
                        m_arvalid <= 1'b1;
                        rstate    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        rstate    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (m_rvalid) begin
                        mem_rdata <= m_rdata;
                        m_rready  <= 1'b0;
                        rstate    <= ST_DONE;
                    end
                end
                default: rstate <= ST_IDLE;
            endcase
        end
    end

`ifdef AXI_RESP_CHECK_EN
    // Sticky until reset; data is still forwarded on an error response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            axi_err <= 1'b0;
        end else if ((m_bvalid && m_bready && (m_bresp != 2'b00)) ||
                     (m_rvalid && m_rready && (m_rresp != 2'b00))) begin
            axi_err <= 1'b1;
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{m_bresp, m_rresp};
    assign axi_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_axi_lite_master.sv
// Directed testbench for mem_axi_lite_master with a delay-configurable AXI-lite slave model.
// Honors AXI_RESP_CHECK_EN the same way as the design when choosing the expected axi_err.
module tb_mem_axi_lite_master;

    logic        clk;
    logic        rstn;
    logic        mem_wen;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_wvalid;
    logic        mem_ren;
    logic [63:0] mem_raddr;
    logic [63:0] mem_rdata;
    logic        mem_rvalid;
    logic [63:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [63:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    logic        axi_err;
    logic [1:0]  debug_wstate;
    logic [1:0]  debug_rstate;

    int checks = 0;
    int errors = 0;

    mem_axi_lite_master #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk(clk), .rstn(rstn),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_wvalid(mem_wvalid),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .axi_err(axi_err), .debug_wstate(debug_wstate), .debug_rstate(debug_rstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: each ready/valid appears after a configurable number of wait cycles.
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic got_aw, got_w, got_ar;

    assign m_awready = m_awvalid && (aw_cnt >= aw_delay);
    assign m_wready  = m_wvalid && (w_cnt >= w_delay);
    assign m_bvalid  = got_aw && got_w && (b_cnt >= b_delay);
    assign m_arready = m_arvalid && (ar_cnt >= ar_delay);
    assign m_rvalid  = got_ar && (r_cnt >= r_delay);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0;
        end else begin
            aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
            ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
            if (m_awvalid && m_awready) got_aw <= 1'b1;
            if (m_wvalid && m_wready) got_w <= 1'b1;
            if (m_bvalid && m_bready) begin
                got_aw <= 1'b0; got_w <= 1'b0; b_cnt <= 0;
            end else if (got_aw && got_w) begin
                b_cnt <= b_cnt + 1;
            end
            if (m_arvalid && m_arready) got_ar <= 1'b1;
            if (m_rvalid && m_rready) begin
                got_ar <= 1'b0; r_cnt <= 0;
            end else if (got_ar) begin
                r_cnt <= r_cnt + 1;
            end
        end
    end

    // Monitor: handshake/pulse counters and a stability check on pending valids.
    int aw_hs = 0, w_hs = 0, ar_hs = 0, aw_high = 0, w_high = 0, wv_pulses = 0, rv_pulses = 0;
    int proto_err = 0;
    logic [63:0] last_awaddr, last_wdata, last_araddr;
    logic [7:0]  last_wstrb;
    logic aw_pend, w_pend, ar_pend;
    logic [63:0] aw_hold, w_hold, ar_hold;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
        end else begin
            if (aw_pend && (!m_awvalid || m_awaddr !== aw_hold)) proto_err <= proto_err + 1;
            if (w_pend && (!m_wvalid || m_wdata !== w_hold)) proto_err <= proto_err + 1;
            if (ar_pend && (!m_arvalid || m_araddr !== ar_hold)) proto_err <= proto_err + 1;
            aw_pend <= m_awvalid && !m_awready; aw_hold <= m_awaddr;
            w_pend  <= m_wvalid && !m_wready;   w_hold  <= m_wdata;
            ar_pend <= m_arvalid && !m_arready; ar_hold <= m_araddr;
            if (m_awvalid) aw_high <= aw_high + 1;
            if (m_wvalid) w_high <= w_high + 1;
            if (m_awvalid && m_awready) begin aw_hs <= aw_hs + 1; last_awaddr <= m_awaddr; end
            if (m_wvalid && m_wready) begin
                w_hs <= w_hs + 1; last_wdata <= m_wdata; last_wstrb <= m_wstrb;
            end
            if (m_arvalid && m_arready) begin ar_hs <= ar_hs + 1; last_araddr <= m_araddr; end
            if (mem_wvalid) wv_pulses <= wv_pulses + 1;
            if (mem_rvalid) rv_pulses <= rv_pulses + 1;
        end
    end

`ifdef AXI_RESP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    // Issues one write and returns the number of cycles until mem_wvalid, or -1 on timeout.
    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                            output int cyc);
        mem_waddr = a; mem_wdata = d; mem_wmask = m; mem_wen = 1'b1;
        cyc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_wvalid) begin cyc = i + 1; break; end
        end
        mem_wen = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] a, output int cyc);
        mem_raddr = a; mem_ren = 1'b1;
        cyc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_rvalid) begin cyc = i + 1; break; end
        end
        mem_ren = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, mem_wvalid, mem_rvalid, axi_err} !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_ctrl got %b want 00000000",
                {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, mem_wvalid, mem_rvalid, axi_err});
        end
        checks++;
        if ({m_awaddr, m_wdata, m_wstrb, m_araddr, mem_rdata, debug_wstate, debug_rstate} !== '0) begin
            errors++; $display("[TB] FAIL reset_data awaddr=%h wdata=%h rdata=%h ws=%0d rs=%0d want all 0",
                m_awaddr, m_wdata, mem_rdata, debug_wstate, debug_rstate);
        end
    endtask

    task automatic test_write_basic;
        int cyc, p0;
        p0 = wv_pulses;
        mem_waddr = 64'h1000; mem_wdata = 64'hDEADBEEF_0000_0001; mem_wmask = 8'hFF; mem_wen = 1'b1;
        @(negedge clk);
        checks++;
        if (!(m_awvalid && m_wvalid && m_awaddr === 64'h1000 && m_wstrb === 8'hFF && m_awprot === 3'b000)) begin
            errors++; $display("[TB] FAIL wr_cycle1 awv=%b wv=%b awaddr=%h wstrb=%h prot=%0d want 1 1 1000 ff 0",
                m_awvalid, m_wvalid, m_awaddr, m_wstrb, m_awprot);
        end
        @(negedge clk);
        checks++;
        if (!(m_bready && !m_awvalid && !m_wvalid && m_bvalid)) begin
            errors++; $display("[TB] FAIL wr_cycle2 bready=%b bvalid=%b awv=%b wv=%b want 1 1 0 0",
                m_bready, m_bvalid, m_awvalid, m_wvalid);
        end
        @(negedge clk);
        checks++;
        if (mem_wvalid !== 1'b1 || debug_wstate !== 2'd3) begin
            errors++; $display("[TB] FAIL wr_cycle3 mem_wvalid=%b state=%0d want 1 3", mem_wvalid, debug_wstate);
        end
        mem_wen = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_wvalid !== 1'b0 || debug_wstate !== 2'd0 || wv_pulses - p0 !== 1) begin
            errors++; $display("[TB] FAIL wr_pulse_end mem_wvalid=%b state=%0d pulses=%0d want 0 0 1",
                mem_wvalid, debug_wstate, wv_pulses - p0);
        end
        checks++;
        if (last_awaddr !== 64'h1000 || last_wdata !== 64'hDEADBEEF_0000_0001 || last_wstrb !== 8'hFF) begin
            errors++; $display("[TB] FAIL wr_beats awaddr=%h wdata=%h wstrb=%h want 1000 deadbeef00000001 ff",
                last_awaddr, last_wdata, last_wstrb);
        end
        cyc = 0;
    endtask

    task automatic test_write_stall;
        int cyc, awh0, wh0, p0;
        awh0 = aw_high; wh0 = w_high; p0 = wv_pulses;
        aw_delay = 2;
        do_write(64'h3008, 64'h0123_4567_89AB_CDEF, 8'h0F, cyc);
        @(negedge clk);
        aw_delay = 0;
        checks++;
        if (cyc !== 5) begin
            errors++; $display("[TB] FAIL wr_stall_latency got %0d want 5", cyc);
        end
        checks++;
        if (aw_high - awh0 !== 3 || w_high - wh0 !== 1) begin
            errors++; $display("[TB] FAIL wr_stall_valid_cycles aw=%0d w=%0d want 3 1", aw_high - awh0, w_high - wh0);
        end
        checks++;
        if (wv_pulses - p0 !== 1 || last_awaddr !== 64'h3008 || last_wstrb !== 8'h0F) begin
            errors++; $display("[TB] FAIL wr_stall_result pulses=%0d awaddr=%h wstrb=%h want 1 3008 0f",
                wv_pulses - p0, last_awaddr, last_wstrb);
        end
    endtask

    task automatic test_read_stall;
        int cyc, p0;
        p0 = rv_pulses;
        r_delay = 2; m_rdata = 64'h1234; m_rresp = 2'b00;
        do_read(64'h2000, cyc);
        checks++;
        if (cyc !== 5 || mem_rdata !== 64'h1234) begin
            errors++; $display("[TB] FAIL rd_stall got cyc=%0d rdata=%h want 5 1234", cyc, mem_rdata);
        end
        m_rdata = 64'hFFFF_0000_FFFF_0000;
        r_delay = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_rdata !== 64'h1234 || mem_rvalid !== 1'b0 || rv_pulses - p0 !== 1 || last_araddr !== 64'h2000) begin
            errors++; $display("[TB] FAIL rd_hold rdata=%h rvalid=%b pulses=%0d araddr=%h want 1234 0 1 2000",
                mem_rdata, mem_rvalid, rv_pulses - p0, last_araddr);
        end
    endtask

    task automatic test_back_to_back;
        int aw0, w0, ar0, wp0, rp0;
        logic wdone, rdone;
        aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; wp0 = wv_pulses; rp0 = rv_pulses;
        wdone = 1'b0; rdone = 1'b0;
        m_rdata = 64'hA5A5_5A5A_0F0F_F0F0;
        mem_waddr = 64'h4000; mem_wdata = 64'h1111_2222_3333_4444; mem_wmask = 8'h3C; mem_wen = 1'b1;
        mem_raddr = 64'h5000; mem_ren = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_wvalid) begin wdone = 1'b1; mem_wen = 1'b0; end
            if (mem_rvalid) begin rdone = 1'b1; mem_ren = 1'b0; end
            if (wdone && rdone) break;
        end
        mem_wen = 1'b0; mem_ren = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (!(wdone && rdone)) begin
            errors++; $display("[TB] FAIL b2b_complete wdone=%b rdone=%b want 1 1", wdone, rdone);
        end
        checks++;
        if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1 || ar_hs - ar0 !== 1) begin
            errors++; $display("[TB] FAIL b2b_beats aw=%0d w=%0d ar=%0d want 1 1 1", aw_hs - aw0, w_hs - w0, ar_hs - ar0);
        end
        checks++;
        if (wv_pulses - wp0 !== 1 || rv_pulses - rp0 !== 1 || mem_rdata !== 64'hA5A5_5A5A_0F0F_F0F0) begin
            errors++; $display("[TB] FAIL b2b_pulses w=%0d r=%0d rdata=%h want 1 1 a5a55a5a0f0ff0f0",
                wv_pulses - wp0, rv_pulses - rp0, mem_rdata);
        end
    endtask

    task automatic test_reset_mid;
        int p0;
        logic reached;
        p0 = wv_pulses; reached = 1'b0;
        b_delay = 5;
        mem_waddr = 64'h6000; mem_wdata = 64'h77; mem_wmask = 8'h01; mem_wen = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (debug_wstate == 2'd2) begin reached = 1'b1; break; end
        end
        checks++;
        if (!reached || m_bready !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_mid_reach_resp reached=%b bready=%b want 1 1", reached, m_bready);
        end
        #1 rstn = 1'b0;
        mem_wen = 1'b0;
        #1;
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, mem_wvalid} !== 6'b0 ||
            debug_wstate !== 2'd0 || debug_rstate !== 2'd0) begin
            errors++; $display("[TB] FAIL rst_mid_async ctrl=%b ws=%0d rs=%0d want 000000 0 0",
                {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, mem_wvalid}, debug_wstate, debug_rstate);
        end
        @(negedge clk);
        rstn = 1'b1;
        b_delay = 0;
        repeat (8) @(negedge clk);
        checks++;
        if (wv_pulses - p0 !== 0 || m_awvalid !== 1'b0 || debug_wstate !== 2'd0) begin
            errors++; $display("[TB] FAIL rst_mid_after pulses=%0d awv=%b ws=%0d want 0 0 0",
                wv_pulses - p0, m_awvalid, debug_wstate);
        end
    endtask

    task automatic test_resp_err;
        int cyc;
        checks++;
        if (axi_err !== 1'b0) begin
            errors++; $display("[TB] FAIL err_initial got %b want 0", axi_err);
        end
        m_bresp = 2'b10;
        do_write(64'h7000, 64'h55, 8'h01, cyc);
        m_bresp = 2'b00;
        @(negedge clk);
        checks++;
        if (cyc !== 3 || axi_err !== EXP_ERR) begin
            errors++; $display("[TB] FAIL err_slverr cyc=%0d axi_err=%b want 3 %b", cyc, axi_err, EXP_ERR);
        end
        do_write(64'h7008, 64'h66, 8'h01, cyc);
        @(negedge clk);
        checks++;
        if (axi_err !== EXP_ERR) begin
            errors++; $display("[TB] FAIL err_sticky got %b want %b", axi_err, EXP_ERR);
        end
        m_rresp = 2'b11; m_rdata = 64'hCAFE;
        do_read(64'h7010, cyc);
        m_rresp = 2'b00;
        @(negedge clk);
        checks++;
        if (mem_rdata !== 64'hCAFE || axi_err !== EXP_ERR) begin
            errors++; $display("[TB] FAIL err_read rdata=%h axi_err=%b want cafe %b", mem_rdata, axi_err, EXP_ERR);
        end
    endtask

    task automatic test_protocol;
        checks++;
        if (proto_err !== 0) begin
            errors++; $display("[TB] FAIL valid_stability got %0d violations want 0", proto_err);
        end
    endtask

    initial begin
        rstn = 1'b0;
        mem_wen = 1'b0; mem_waddr = '0; mem_wdata = '0; mem_wmask = '0;
        mem_ren = 1'b0; mem_raddr = '0;
        m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
        repeat (2) @(negedge clk);
        test_reset;
        rstn = 1'b1;
        @(negedge clk);
        test_write_basic;
        test_write_stall;
        test_read_stall;
        test_back_to_back;
        test_reset_mid;
        test_resp_err;
        test_protocol;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
